collision_probe_seq: RTL and testbench

//  Parametrised successor to the sprite wall checker. On a request it latches sprite

---
 rtl/collision_probe_seq.sv | 217 +++++++++++++++++++++
 tb/tb_collision_probe_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_probe_seq.sv
// collision_probe_seq
//   Sprite-versus-map collision checker. On an accepted request it latches the
//   sprite centre and a one-hot direction, then walks three probe points
//   (centre-forward, first side, second side) through a single shared mapRom
//   read port, one probe at a time. Each probe holds its address for
//   ROM_LAT+1 cycles and samples rom_pixel in the last of those cycles.
//
//   Optional feature macro: COLLIDE_BOUNDS_EN
//     defined   : probes outside [0,MAP_W) x [0,MAP_H) count as hits without
//                 looking at rom_pixel (rom_x/rom_y still show the wrapped value)
//     undefined : wrapped address goes to mapRom, rom_pixel alone decides
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset
//     req        start a check (accepted when busy=0)
//     direction  one-hot: 1000 left, 0100 up, 0010 right, 0001 down
//     p_x, p_y   sprite centre, sampled on accept
//     rom_x/y    probe address to mapRom
//     rom_pixel  mapRom data, valid ROM_LAT cycles after the address
//     busy       check in progress, req ignored
//     done       one-cycle pulse, results valid
//     collide    OR of hit_mask
//     hit_mask   bit0 centre, bit1 first side, bit2 second side
//     bad_dir    last accepted request had a non-one-hot direction
module collision_probe_seq #(
   parameter int COORD_W   = 9,
   parameter int PIXEL_W   = 3,
   parameter int WALL_CODE = 0,
   parameter int STEP      = 12,
   parameter int INSET     = 4,
   parameter int ROM_LAT   = 1,
   parameter int MAP_W     = 320,
   parameter int MAP_H     = 240
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   input  logic [3:0]         direction,
   input  logic [COORD_W-1:0] p_x,
   input  logic [COORD_W-1:0] p_y,
   output logic [COORD_W-1:0] rom_x,
   output logic [COORD_W-1:0] rom_y,
   input  logic [PIXEL_W-1:0] rom_pixel,
   output logic               busy,
   output logic               done,
   output logic               collide,
   output logic [2:0]         hit_mask,
   output logic               bad_dir
);

   localparam int                 CNT_W = $clog2(ROM_LAT + 2);
   localparam logic [COORD_W-1:0] OFF_S = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] OFF_D = COORD_W'(STEP - INSET);
   localparam logic [PIXEL_W-1:0] WALL  = PIXEL_W'(WALL_CODE);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(ROM_LAT);

   // The signed probe coordinate is COORD_W+1 bits, so the map limits must
   // stay below 2^COORD_W to be representable as positive values.
   if (MAP_W >= (1 << COORD_W) || MAP_H >= (1 << COORD_W)) begin : g_map_range
      $error("MAP_W/MAP_H must be below 2**COORD_W");
   end

   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_REJECT, S_DONE} state_t;

   // Offsets are returned as COORD_W-bit two's complement so that adding them
   // to an unsigned coordinate wraps modulo 2^COORD_W.
   function automatic logic [COORD_W-1:0] off_x(input logic [3:0] dir, input logic [1:0] k);
      logic [COORD_W-1:0] r;
      r = '0;
      case (dir)
         4'b1000: r = (k == 2'd0) ? -OFF_S : -OFF_D;
         4'b0100: r = (k == 2'd0) ? '0 : ((k == 2'd1) ? -OFF_D : OFF_D);
         4'b0010: r = (k == 2'd0) ? OFF_S : OFF_D;
         4'b0001: r = (k == 2'd0) ? '0 : ((k == 2'd1) ? -OFF_D : OFF_D);
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [COORD_W-1:0] off_y(input logic [3:0] dir, input logic [1:0] k);
      logic [COORD_W-1:0] r;
      r = '0;
      case (dir)
         4'b1000: r = (k == 2'd0) ? '0 : ((k == 2'd1) ? OFF_D : -OFF_D);
         4'b0100: r = (k == 2'd0) ? -OFF_S : -OFF_D;
         4'b0010: r = (k == 2'd0) ? '0 : ((k == 2'd1) ? -OFF_D : OFF_D);
         4'b0001: r = (k == 2'd0) ? OFF_S : OFF_D;
         default: r = '0;
      endcase
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         k_q, k_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         hit_q, hit_d;
   logic               bad_q, bad_d;
   logic [COORD_W-1:0] romx_q, romx_d, romy_q, romy_d;
   logic [3:0]         dir_q;
   logic [COORD_W-1:0] px_q, py_q;
   logic               load;
   logic               probe_hit;

`ifdef COLLIDE_BOUNDS_EN
   localparam logic signed [COORD_W:0] LIM_X = (COORD_W+1)'(MAP_W);
   localparam logic signed [COORD_W:0] LIM_Y = (COORD_W+1)'(MAP_H);
   logic [COORD_W-1:0]      cur_ox, cur_oy;
   logic signed [COORD_W:0] cur_sx, cur_sy;

   // Unwrapped position of the probe currently on the bus; sign bit set
   // means it fell off the top/left edge of the map.
   always_comb begin
      cur_ox = off_x(dir_q, k_q);
      cur_oy = off_y(dir_q, k_q);
      cur_sx = $signed({1'b0, px_q}) + $signed({cur_ox[COORD_W-1], cur_ox});
      cur_sy = $signed({1'b0, py_q}) + $signed({cur_oy[COORD_W-1], cur_oy});
   end

   assign probe_hit = cur_sx[COORD_W] || (cur_sx >= LIM_X) ||
                      cur_sy[COORD_W] || (cur_sy >= LIM_Y) ||
                      (rom_pixel == WALL);
`else
   assign probe_hit = (rom_pixel == WALL);
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
      bad_d   = bad_q;
      romx_d  = romx_q;
      romy_d  = romy_q;
      load    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            done    = (state_q == S_DONE);
            state_d = S_IDLE;
            if (req) begin
               load  = 1'b1;
               hit_d = '0;
               k_d   = 2'd0;
               cnt_d = '0;
               bad_d = !$onehot(direction);
               if ($onehot(direction)) begin
                  state_d = S_PROBE;
                  romx_d  = p_x + off_x(direction, 2'd0);
                  romy_d  = p_y + off_y(direction, 2'd0);
               end else begin
                  // Address bus keeps its previous value on a rejected request.
                  state_d = S_REJECT;
               end
            end
         end
         S_PROBE: begin
            busy = 1'b1;
            if (cnt_q == LAST) begin
               hit_d[k_q] = probe_hit;
               cnt_d      = '0;
               if (k_q == 2'd2) begin
                  state_d = S_DONE;
               end else begin
                  k_d    = k_q + 2'd1;
                  romx_d = px_q + off_x(dir_q, k_q + 2'd1);
                  romy_d = py_q + off_y(dir_q, k_q + 2'd1);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REJECT: begin
            busy    = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= 2'd0;
         cnt_q   <= '0;
         hit_q   <= '0;
         bad_q   <= 1'b0;
         romx_q  <= '0;
         romy_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         bad_q   <= bad_d;
         romx_q  <= romx_d;
         romy_q  <= romy_d;
      end
   end

   // Request operands: captured on accept only, so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (load) begin
         dir_q <= direction;
         px_q  <= p_x;
         py_q  <= p_y;
      end
   end

   assign rom_x    = romx_q;
   assign rom_y    = romy_q;
   assign hit_mask = hit_q;
   assign collide  = |hit_q;
   assign bad_dir  = bad_q;

endmodule

// File: tb/tb_collision_probe_seq.sv
module tb_collision_probe_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Three instances that differ only in mapRom latency (0, 1, 2).
   logic       rstn_a [3];
   logic       req_a  [3];
   logic [3:0] dir_a  [3];
   logic [8:0] px_a   [3];
   logic [8:0] py_a   [3];
   wire  [8:0] rx_w   [3];
   wire  [8:0] ry_w   [3];
   wire  [2:0] pix_w  [3];
   wire        busy_w [3];
   wire        done_w [3];
   wire        col_w  [3];
   wire  [2:0] hit_w  [3];
   wire        bad_w  [3];

   int mode, wx, wy, seed;
   int n_cmp  = 0;
   int n_fail = 0;

   // Probe offset tables written straight from the direction/offset rules:
   // row = left, up, right, down ; column = probe 0,1,2 ; S=12, D=8.
   int OFFX [4][3] = '{'{-12, -8, -8}, '{  0, -8,  8}, '{12,  8,  8}, '{ 0, -8,  8}};
   int OFFY [4][3] = '{'{  0,  8, -8}, '{-12, -8, -8}, '{ 0, -8,  8}, '{12,  8,  8}};

   // Map contents: 0 open floor (pixel 1 everywhere), 1 single wall cell,
   // 2 pseudo-random pattern with walls (code 0) on roughly one cell in five.
   function automatic logic [2:0] map_pix(input logic [8:0] x, input logic [8:0] y,
                                          input int md, input int wxx, input int wyy, input int sd);
      int xi, yi;
      xi = int'(x);
      yi = int'(y);
      if (md == 0) return 3'd1;
      if (md == 1) return (xi == wxx && yi == wyy) ? 3'd0 : 3'd1;
      if (((xi * 7 + yi * 3 + sd) % 5) == 0) return 3'd0;
      return 3'(1 + ((xi + yi) % 7));
   endfunction

   // Reference: expected wrapped addresses and hit mask for a valid request.
   function automatic void ref_model(input logic [3:0] dir, input int px, input int py,
                                     output logic [26:0] exs, output logic [26:0] eys,
                                     output logic [2:0] eh);
      int di, tx, ty;
      bit oob;
      exs = '0; eys = '0; eh = '0;
      di = dir[3] ? 0 : dir[2] ? 1 : dir[1] ? 2 : 3;
      for (int k = 0; k < 3; k++) begin
         tx = px + OFFX[di][k];
         ty = py + OFFY[di][k];
         exs[k*9 +: 9] = 9'(tx & 511);
         eys[k*9 +: 9] = 9'(ty & 511);
         oob = 1'b0;
`ifdef COLLIDE_BOUNDS_EN
         oob = (tx < 0) || (tx >= 320) || (ty < 0) || (ty >= 240);
`endif
         eh[k] = oob || (map_pix(9'(tx & 511), 9'(ty & 511), mode, wx, wy, seed) == 3'd0);
      end
   endfunction

   collision_probe_seq #(.ROM_LAT(0)) u0 (
      .clk(clk), .rst_n(rstn_a[0]), .req(req_a[0]), .direction(dir_a[0]),
      .p_x(px_a[0]), .p_y(py_a[0]), .rom_x(rx_w[0]), .rom_y(ry_w[0]),
      .rom_pixel(pix_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .collide(col_w[0]), .hit_mask(hit_w[0]), .bad_dir(bad_w[0]));

   collision_probe_seq #(.ROM_LAT(1)) u1 (
      .clk(clk), .rst_n(rstn_a[1]), .req(req_a[1]), .direction(dir_a[1]),
      .p_x(px_a[1]), .p_y(py_a[1]), .rom_x(rx_w[1]), .rom_y(ry_w[1]),
      .rom_pixel(pix_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .collide(col_w[1]), .hit_mask(hit_w[1]), .bad_dir(bad_w[1]));

   collision_probe_seq #(.ROM_LAT(2)) u2 (
      .clk(clk), .rst_n(rstn_a[2]), .req(req_a[2]), .direction(dir_a[2]),
      .p_x(px_a[2]), .p_y(py_a[2]), .rom_x(rx_w[2]), .rom_y(ry_w[2]),
      .rom_pixel(pix_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .collide(col_w[2]), .hit_mask(hit_w[2]), .bad_dir(bad_w[2]));

   // mapRom models with 0, 1 and 2 cycles of address-to-data latency.
   logic [8:0] d1x, d1y, d2ax, d2ay, d2bx, d2by;
   always @(posedge clk) begin
      d1x  <= rx_w[1]; d1y  <= ry_w[1];
      d2ax <= rx_w[2]; d2ay <= ry_w[2];
      d2bx <= d2ax;    d2by <= d2ay;
   end
   assign pix_w[0] = map_pix(rx_w[0], ry_w[0], mode, wx, wy, seed);
   assign pix_w[1] = map_pix(d1x, d1y, mode, wx, wy, seed);
   assign pix_w[2] = map_pix(d2bx, d2by, mode, wx, wy, seed);

   // One request on instance inst, checked every cycle until two cycles after done.
   task automatic check_one(input int inst, input logic [3:0] dir, input int px, input int py,
                            input string tag);
      int L, P;
      bit good;
      logic [26:0] exs, eys;
      logic [2:0]  eh;
      logic [8:0]  rx0, ry0;
      logic [19:0] got, exp;
      L = inst;
      P = 3 * (L + 1);
      good = $onehot(dir);
      exs = '0; eys = '0; eh = '0;
      if (good) ref_model(dir, px, py, exs, eys, eh);
      rx0 = rx_w[inst];
      ry0 = ry_w[inst];
      req_a[inst] = 1'b1; dir_a[inst] = dir; px_a[inst] = 9'(px); py_a[inst] = 9'(py);
      @(posedge clk);
      @(negedge clk);
      req_a[inst] = 1'b0;
      dir_a[inst] = 4'($urandom); px_a[inst] = 9'($urandom); py_a[inst] = 9'($urandom);
      for (int n = 0; n <= P + 2; n++) begin
         if (good && n < P) begin
            got = {busy_w[inst], done_w[inst], rx_w[inst], ry_w[inst]};
            exp = {1'b1, 1'b0, exs[(n/(L+1))*9 +: 9], eys[(n/(L+1))*9 +: 9]};
         end else if (good) begin
            got = {13'd0, busy_w[inst], done_w[inst], col_w[inst], hit_w[inst], bad_w[inst]};
            exp = {13'd0, 1'b0, (n == P), |eh, eh, 1'b0};
         end else if (n == 0) begin
            got = {busy_w[inst], done_w[inst], rx_w[inst], ry_w[inst]};
            exp = {1'b1, 1'b0, rx0, ry0};
         end else begin
            got = {13'd0, busy_w[inst], done_w[inst], col_w[inst], hit_w[inst], bad_w[inst]};
            exp = {13'd0, 1'b0, (n == 1), 1'b0, 3'b000, 1'b1};
         end
         n_cmp++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d cycle=%0d got=%h expected=%h", tag, inst, n, got, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [26:0] got;
      for (int i = 0; i < 3; i++) begin
         rstn_a[i] = 1'b0; req_a[i] = 1'b1; dir_a[i] = 4'b0010; px_a[i] = 9'd100; py_a[i] = 9'd100;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         got = {busy_w[i], done_w[i], col_w[i], hit_w[i], bad_w[i], rx_w[i], ry_w[i]};
         n_cmp++;
         if (got !== 27'd0) begin
            n_fail++;
            $display("FAIL reset lat=%0d got=%h expected=0", i, got);
         end
         rstn_a[i] = 1'b1; req_a[i] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_open_floor();
      mode = 0;
      for (int i = 0; i < 3; i++) begin
         check_one(i, 4'b0010, 100, 100, "open_floor");
         n_cmp++;
         if ({col_w[i], hit_w[i]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL open_floor_result lat=%0d got=%b expected=0000", i, {col_w[i], hit_w[i]});
         end
      end
   endtask

   task automatic test_wall();
      mode = 1; wx = 88; wy = 100;
      check_one(1, 4'b1000, 100, 100, "wall_centre");
      n_cmp++;
      if ({col_w[1], hit_w[1]} !== 4'b1001) begin
         n_fail++;
         $display("FAIL wall_centre_result got=%b expected=1001", {col_w[1], hit_w[1]});
      end
      wx = 92; wy = 92;
      check_one(1, 4'b1000, 100, 100, "wall_side2");
      n_cmp++;
      if ({col_w[1], hit_w[1]} !== 4'b1100) begin
         n_fail++;
         $display("FAIL wall_side2_result got=%b expected=1100", {col_w[1], hit_w[1]});
      end
   endtask

   task automatic test_bad_dir();
      mode = 0;
      for (int i = 0; i < 3; i++) begin
         check_one(i, 4'b0110, 50, 60, "bad_dir");
         n_cmp++;
         if (bad_w[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_dir_flag lat=%0d got=%b expected=1", i, bad_w[i]);
         end
         check_one(i, 4'b0000, 70, 80, "bad_dir_zero");
         check_one(i, 4'b0100, 150, 120, "bad_dir_cleared");
      end
   endtask

   task automatic test_back_to_back(input int inst);
      int L, P, ndone;
      bit dexp;
      logic [26:0] exs, eys;
      logic [2:0]  eh;
      logic [4:0]  got, exp;
      L = inst;
      P = 3 * (L + 1);
      mode = 2; seed = int'($urandom_range(0, 1000));
      ref_model(4'b0001, 200, 150, exs, eys, eh);
      req_a[inst] = 1'b1; dir_a[inst] = 4'b0001; px_a[inst] = 9'd200; py_a[inst] = 9'd150;
      @(posedge clk);
      @(negedge clk);
      ndone = 0;
      for (int n = 0; n <= 3 * P + 2; n++) begin
         dexp = (n >= P) && (((n - P) % (P + 1)) == 0);
         ndone += int'(done_w[inst]);
         got = dexp ? {busy_w[inst], done_w[inst], hit_w[inst]} : {busy_w[inst], done_w[inst], 3'b000};
         exp = dexp ? {1'b0, 1'b1, eh} : {1'b1, 1'b0, 3'b000};
         n_cmp++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL back_to_back lat=%0d cycle=%0d got=%b expected=%b", inst, n, got, exp);
         end
         if (n == 3 * P + 2) req_a[inst] = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if ({busy_w[inst], done_w[inst]} !== 2'b00 || ndone != 3) begin
         n_fail++;
         $display("FAIL back_to_back_count lat=%0d dones=%0d expected=3 busy/done=%b",
                  inst, ndone, {busy_w[inst], done_w[inst]});
      end
   endtask

   task automatic test_reset_mid(input int inst);
      int L, P, ndone;
      logic [26:0] got;
      L = inst;
      P = 3 * (L + 1);
      mode = 1; wx = 112; wy = 100;
      req_a[inst] = 1'b1; dir_a[inst] = 4'b0010; px_a[inst] = 9'd100; py_a[inst] = 9'd100;
      @(posedge clk);
      @(negedge clk);
      req_a[inst] = 1'b0;
      repeat (L + 1) @(negedge clk);
      rstn_a[inst] = 1'b0;
      @(negedge clk);
      got = {busy_w[inst], done_w[inst], col_w[inst], hit_w[inst], bad_w[inst], rx_w[inst], ry_w[inst]};
      n_cmp++;
      if (got !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_mid lat=%0d got=%h expected=0", inst, got);
      end
      rstn_a[inst] = 1'b1;
      ndone = 0;
      for (int n = 0; n < 2 * P + 4; n++) begin
         @(negedge clk);
         ndone += int'(done_w[inst]) + int'(busy_w[inst]);
      end
      n_cmp++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet lat=%0d busy_or_done_cycles=%0d expected=0", inst, ndone);
      end
   endtask

   task automatic test_wrap();
      mode = 0;
      for (int i = 0; i < 3; i++) begin
         check_one(i, 4'b1000, 5, 100, "wrap_left");
         n_cmp++;
`ifdef COLLIDE_BOUNDS_EN
         if (hit_w[i] !== 3'b111) begin
            n_fail++;
            $display("FAIL wrap_result lat=%0d got=%b expected=111", i, hit_w[i]);
         end
`else
         if (hit_w[i] !== 3'b000) begin
            n_fail++;
            $display("FAIL wrap_result lat=%0d got=%b expected=000", i, hit_w[i]);
         end
`endif
      end
      mode = 2; seed = 17;
      check_one(1, 4'b1000, 5, 100, "wrap_pattern");
      check_one(2, 4'b0001, 300, 235, "wrap_bottom");
      check_one(0, 4'b0100, 507, 3, "wrap_top");
   endtask

   task automatic test_random();
      int inst;
      logic [3:0] dir;
      for (int it = 0; it < 24; it++) begin
         inst = int'($urandom_range(0, 2));
         mode = 2; seed = int'($urandom_range(0, 1000));
         if ($urandom_range(0, 5) == 0) dir = 4'($urandom);
         else dir = 4'(1 << $urandom_range(0, 3));
         check_one(inst, dir, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), "random");
      end
   endtask

   initial begin
      mode = 0; wx = 0; wy = 0; seed = 0;
      for (int i = 0; i < 3; i++) begin
         rstn_a[i] = 1'b0; req_a[i] = 1'b0; dir_a[i] = 4'b0000; px_a[i] = '0; py_a[i] = '0;
      end
      test_reset();
      test_open_floor();
      test_wall();
      test_bad_dir();
      test_back_to_back(1);
      test_back_to_back(0);
      test_back_to_back(2);
      test_reset_mid(1);
      test_reset_mid(2);
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
